// File: rtl/plc_input_filter_if.sv
// Discrete input bus between the IN pins and the IL core's input image.
// The evt_* signals exist only when PLC_FILTER_EDGE_LATCH_EN is defined.
interface plc_input_filter_if #(
    parameter int N_IN = 8
);
    logic            enable;
    logic [N_IN-1:0] in_raw;
    logic [N_IN-1:0] in_filt;
    logic [N_IN-1:0] rise;
    logic [N_IN-1:0] fall;
`ifdef PLC_FILTER_EDGE_LATCH_EN
    logic [N_IN-1:0] evt_clr;
    logic [N_IN-1:0] evt_lat;
    logic            evt_any;

    modport master (
        output enable, in_raw, evt_clr,
        input  in_filt, rise, fall, evt_lat, evt_any
    );
    modport slave (
        input  enable, in_raw, evt_clr,
        output in_filt, rise, fall, evt_lat, evt_any
    );
`else
    modport master (
        output enable, in_raw,
        input  in_filt, rise, fall
    );
    modport slave (
        input  enable, in_raw,
        output in_filt, rise, fall
    );
`endif
endinterface

// File: rtl/plc_input_filter.sv
// Per-channel 2-flop sync, prescaled-tick debounce and edge pulses for the IN bus.
// Optional sticky edge-event latch: define PLC_FILTER_EDGE_LATCH_EN.
module plc_input_filter #(
    parameter int N_IN       = 8,
    parameter int DEB_CYCLES = 4,
    parameter int PRESCALE   = 16
) (
    input  logic                clk,
    input  logic                reset,
    plc_input_filter_if.slave   bus
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam int PS_W  = $clog2(PRESCALE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);
    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);

    logic [N_IN-1:0] s1_q, s2_q;
    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick;
    logic [N_IN-1:0] filt_w, rise_w, fall_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            ps_q <= '0;
        end else begin
            s1_q <= bus.in_raw;
            s2_q <= s1_q;
            ps_q <= ps_d;
        end
    end

    // Tick is qualified by enable so a disabled filter freezes every channel.
    always_comb begin
        tick = bus.enable && (ps_q == PS_MAX);
        ps_d = ps_q;
        if (bus.enable)
            ps_d = tick ? '0 : ps_q + PS_W'(1);
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_lane
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             filt_q, filt_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;

        always_comb begin
            cnt_d  = cnt_q;
            filt_d = filt_q;
            rise_d = 1'b0;
            fall_d = 1'b0;
            if (tick) begin
                if (s2_q[i] == filt_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    filt_d = s2_q[i];
                    cnt_d  = '0;
                    rise_d = s2_q[i];
                    fall_d = ~s2_q[i];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q  <= '0;
                filt_q <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                filt_q <= filt_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end

        assign filt_w[i] = filt_q;
        assign rise_w[i] = rise_q;
        assign fall_w[i] = fall_q;
    end

    assign bus.in_filt = filt_w;
    assign bus.rise    = rise_w;
    assign bus.fall    = fall_w;

`ifdef PLC_FILTER_EDGE_LATCH_EN
    logic [N_IN-1:0] evt_q, evt_d;

    // A new edge outranks a clear arriving in the same cycle.
    always_comb evt_d = (evt_q & ~bus.evt_clr) | rise_w | fall_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) evt_q <= '0;
        else        evt_q <= evt_d;
    end

    assign bus.evt_lat = evt_q;
    assign bus.evt_any = |evt_q;
`endif
endmodule

// File: tb/tb_plc_input_filter.sv
// Scoreboard bench: dut1 (PRESCALE=1, DEB=4), dut2 (PRESCALE=16, DEB=4), dut3 (PRESCALE=1, DEB=1).
module tb_plc_input_filter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    plc_input_filter_if #(.N_IN(8)) if1 ();
    plc_input_filter_if #(.N_IN(8)) if2 ();
    plc_input_filter_if #(.N_IN(8)) if3 ();

    plc_input_filter #(.N_IN(8), .DEB_CYCLES(4), .PRESCALE(1))  dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    plc_input_filter #(.N_IN(8), .DEB_CYCLES(4), .PRESCALE(16)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));
    plc_input_filter #(.N_IN(8), .DEB_CYCLES(1), .PRESCALE(1))  dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

    typedef struct {
        int         lo;
        int         hi;
        logic [7:0] filt;
        logic [7:0] rise;
        logic [7:0] fall;
    } ev_t;

    ev_t        sb0[$], sb1[$], sb2[$];
    logic [7:0] exp_f [3] = '{8'h00, 8'h00, 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int lo, input int hi,
                        input logic [7:0] f, input logic [7:0] r, input logic [7:0] fl);
        ev_t e;
        e.lo = lo; e.hi = hi; e.filt = f; e.rise = r; e.fall = fl;
        case (d)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic mon(input int d, input logic [7:0] f, input logic [7:0] r, input logic [7:0] fl);
        ev_t e;
        int  n;
        if (reset !== 1'b1) begin
            exp_f[d] = 8'h00;
            return;
        end
        if (|(r | fl)) begin
            n = (d == 0) ? sb0.size() : (d == 1) ? sb1.size() : sb2.size();
            total++;
            if (n == 0) begin
                bad++;
                $display("FAIL unexpected_edge dut%0d: cycle %0d rise=%h fall=%h, expected none", d, cyc, r, fl);
            end else begin
                case (d)
                    0:       e = sb0.pop_front();
                    1:       e = sb1.pop_front();
                    default: e = sb2.pop_front();
                endcase
                if (cyc < e.lo || cyc > e.hi) begin
                    bad++;
                    $display("FAIL edge_time dut%0d: cycle %0d expected %0d..%0d", d, cyc, e.lo, e.hi);
                end
                total++;
                if ({f, r, fl} !== {e.filt, e.rise, e.fall}) begin
                    bad++;
                    $display("FAIL edge_value dut%0d: filt/rise/fall %h/%h/%h expected %h/%h/%h",
                             d, f, r, fl, e.filt, e.rise, e.fall);
                end
                exp_f[d] = e.filt;
            end
        end else if (f !== exp_f[d]) begin
            total++;
            bad++;
            $display("FAIL filt_hold dut%0d: cycle %0d got %h expected %h", d, cyc, f, exp_f[d]);
        end
    endtask

    always @(negedge clk) begin
        mon(0, if1.in_filt, if1.rise, if1.fall);
        mon(1, if2.in_filt, if2.rise, if2.fall);
        mon(2, if3.in_filt, if3.rise, if3.fall);
    end

    int last_tick = -1;
    int tick_chk  = 0;
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            last_tick = -1;
        end else if (dut2.tick) begin
            if (last_tick >= 0 && tick_chk < 8) begin
                tick_chk++;
                chk("tick_spacing", cyc - last_tick, 16);
            end
            last_tick = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        if1.enable  = 1'b1; if1.in_raw = 8'hFF;
        if2.enable  = 1'b1; if2.in_raw = 8'h00;
        if3.enable  = 1'b1; if3.in_raw = 8'h00;
`ifdef PLC_FILTER_EDGE_LATCH_EN
        if1.evt_clr = 8'h00; if2.evt_clr = 8'h00; if3.evt_clr = 8'h00;
`endif
        step(3);
        chk("reset_filt", if1.in_filt, 8'h00);
        chk("reset_rise", if1.rise, 8'h00);
        chk("reset_fall", if1.fall, 8'h00);
        chk("reset_filt3", if3.in_filt, 8'h00);

        // high pins after release go through the normal 6-edge path
        reset = 1'b1;
        push(0, cyc + 6, cyc + 6, 8'hFF, 8'hFF, 8'h00);
        step(10);

        if1.in_raw = 8'h00; push(0, cyc + 6, cyc + 6, 8'h00, 8'h00, 8'hFF); step(10);
        if1.in_raw = 8'h01; push(0, cyc + 6, cyc + 6, 8'h01, 8'h01, 8'h00); step(10);

        // 3-clk glitch rejected, 4-clk pulse accepted then falls
        if1.in_raw = 8'h09; step(3);
        if1.in_raw = 8'h01; step(10);
        chk("glitch_filt", if1.in_filt, 8'h01);
        if1.in_raw = 8'h09; push(0, cyc + 6, cyc + 6, 8'h09, 8'h08, 8'h00); step(4);
        if1.in_raw = 8'h01; push(0, cyc + 6, cyc + 6, 8'h01, 8'h00, 8'h08); step(10);

        // simultaneous multi-bit changes
        if1.in_raw = 8'h31; push(0, cyc + 6, cyc + 6, 8'h31, 8'h30, 8'h00); step(10);
        if1.in_raw = 8'h00; push(0, cyc + 6, cyc + 6, 8'h00, 8'h00, 8'h31); step(10);

        // pause with cnt=2 for 20 clk; accept 2 ticks after resume
        if1.in_raw = 8'h02; push(0, cyc + 26, cyc + 26, 8'h02, 8'h02, 8'h00); step(4);
        if1.enable = 1'b0; step(20);
        chk("hold_filt", if1.in_filt, 8'h00);
        if1.enable = 1'b1; step(10);

        // prescaled channel
        if2.in_raw = 8'h80; push(1, cyc + 49, cyc + 66, 8'h80, 8'h80, 8'h00); step(70);
        if2.in_raw = 8'h00; push(1, cyc + 49, cyc + 66, 8'h00, 8'h00, 8'h80); step(70);

        // DEB_CYCLES=1 accepts on the first differing tick
        if3.in_raw = 8'h20; push(2, cyc + 3, cyc + 3, 8'h20, 8'h20, 8'h00); step(5);
        if3.in_raw = 8'h00; push(2, cyc + 3, cyc + 3, 8'h00, 8'h00, 8'h20); step(5);

`ifdef PLC_FILTER_EDGE_LATCH_EN
        if1.evt_clr = 8'hFF; step(1);
        if1.evt_clr = 8'h00;
        chk("evt_any_cleared", if1.evt_any, 1'b0);
        if1.in_raw = 8'h06; push(0, cyc + 6, cyc + 6, 8'h06, 8'h04, 8'h00); step(7);
        chk("evt_lat_rise", if1.evt_lat, 8'h04);
        chk("evt_any_set", if1.evt_any, 1'b1);
        if1.in_raw = 8'h02; push(0, cyc + 6, cyc + 6, 8'h02, 8'h00, 8'h04); step(6);
        if1.evt_clr = 8'h04; step(1);
        if1.evt_clr = 8'h00;
        chk("evt_set_wins", if1.evt_lat, 8'h04);
        step(2);
        if1.evt_clr = 8'h04; step(1);
        if1.evt_clr = 8'h00;
        chk("evt_lat_clr", if1.evt_lat, 8'h00);
        chk("evt_any_clr", if1.evt_any, 1'b0);
`endif

        // reset mid-count discards progress; high pins re-accepted after release
        if1.in_raw = 8'h42; step(4);
        reset = 1'b0; #1;
        chk("midreset_filt", if1.in_filt, 8'h00);
        chk("midreset_rise", if1.rise, 8'h00);
        step(2);
        reset = 1'b1;
        push(0, cyc + 6, cyc + 6, 8'h42, 8'h42, 8'h00);
        step(12);

        chk("sb0_empty", sb0.size(), 0);
        chk("sb1_empty", sb1.size(), 0);
        chk("sb2_empty", sb2.size(), 0);
        chk("tick_checks_seen", tick_chk, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/plc_input_filter.md
Name: plc_input_filter

Overview:
- Parametrised, synthesisable conditioning stage for the processor's discrete input bus, placed between the top-level IN pins and the IL core's input image.
- Per channel: synchronises, debounces against a prescaled sample tick, and flags edges.
- Replaces the direct pin-to-core connection, generalising it in channel count, filter depth and sample rate.

Parameters:
N_IN, 8, number of input channels; matches the processor input count.
DEB_CYCLES, 4, consecutive sample ticks a new level must hold before acceptance; must be >=1.
PRESCALE, 16, clk cycles per sample tick; must be >=1, and 1 means a tick every cycle.
CNT_W, $clog2(DEB_CYCLES+1), debounce counter width; derived, not overridden.
PS_W, $clog2(PRESCALE+1), prescaler width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
enable  input  1  1 = filter runs; 0 = prescaler, counters and outputs hold.
in_raw  input  N_IN  asynchronous pin levels.
in_filt  output  N_IN  debounced levels to the core.
rise  output  N_IN  1-clk pulse per channel on an accepted 0->1 change.
fall  output  N_IN  1-clk pulse per channel on an accepted 1->0 change.
evt_clr  input  N_IN  present only with the optional feature.
evt_lat  output  N_IN  present only with the optional feature.
evt_any  output  1  present only with the optional feature.

Behaviour:
- Reset (reset=0, asynchronous) clears to 0:
  - both sync stages, prescaler, all counters;
  - in_filt, rise, fall, and evt_lat when present.
  - Reset mid-debounce discards the partial count.
  - After release, a high pin is treated as a new change and accepted through the normal debounce path.
- Synchroniser: 2-flop chain per bit, in_raw -> s1 -> s2. Only s2 is used downstream.
- Prescaler:
  - When enable=1, counts 0..PRESCALE-1 and wraps.
  - tick=1 in the cycle the count equals PRESCALE-1.
  - When enable=0, count is held and tick=0.
- Per-channel debounce, evaluated only on tick:
  - s2[i]==in_filt[i]: cnt[i] <= 0.
  - s2[i]!=in_filt[i] and cnt[i]==DEB_CYCLES-1: in_filt[i] <= s2[i]; cnt[i] <= 0; rise[i] or fall[i] asserted in the same cycle in_filt[i] changes.
  - otherwise: cnt[i] <= cnt[i]+1.
- No tick: cnt and in_filt hold.
- rise and fall are registered, high for exactly one clk, and deassert the next cycle. The same bit never has both set.
- Latency with PRESCALE=1: in_filt[i] changes on the (DEB_CYCLES+2)th rising edge, counting the edge that first samples the new in_raw level into s1. Default DEB_CYCLES=4 gives 6 edges.
- Glitch rejection: a level lasting fewer than DEB_CYCLES ticks at s2 returns cnt to 0 when s2 re-matches in_filt. No output change.
- Channels are fully independent; simultaneous changes on several bits are each accepted on their own count.
- DEB_CYCLES=1: accepted on the first tick where s2 differs from in_filt.

Optional Feature:
- Macro: PLC_FILTER_EDGE_LATCH_EN.
- Defined:
  - Adds evt_clr, evt_lat and evt_any.
  - evt_lat[i] sets on rise[i] or fall[i] and is sticky.
  - evt_clr[i]=1 clears evt_lat[i] on the next edge.
  - Set and clear in the same cycle: set wins, and evt_lat stays 1.
  - evt_any is the combinational OR of evt_lat.
  - evt_lat is not gated by enable.
- Undefined: those ports and their logic are absent; only the rise/fall pulses exist.

Test Plan:
1. Hold reset=0 with in_raw=8'hFF, then release (PRESCALE=1, DEB_CYCLES=4) -> during reset in_filt=0, rise=0, fall=0; after release in_filt=8'hFF on the 6th edge, with rise=8'hFF for exactly 1 clk.
2. PRESCALE=1, DEB_CYCLES=4, in_filt=0; in_raw[0] goes 0->1 and holds -> in_filt[0]=1 on the 6th edge, rise[0] for 1 clk, fall=0, other bits unchanged.
3. PRESCALE=1; in_raw[3] pulses high for 3 clk -> in_filt[3] stays 0, rise[3] never asserts. A 4-tick stable pulse is accepted, and fall[3] follows after it ends.
4. PRESCALE=16, DEB_CYCLES=4; in_raw[7] 0->1 -> in_filt[7] changes after the 4th tick seen at s2, between 49 and 66 clk; check that ticks are exactly 16 clk apart.
5. Mid-debounce (cnt=2) drive enable=0 for 20 clk, then 1 -> no change while disabled; acceptance completes 2 ticks after resume. Assert reset mid-count -> in_filt=0 and count restarts.
6. With PLC_FILTER_EDGE_LATCH_EN: rise[2] sets evt_lat[2] and evt_any=1. Pulse evt_clr[2] in the same cycle as a new fall[2] -> evt_lat[2] stays 1. A later evt_clr[2] alone gives evt_lat=0 and evt_any=0.
